mlp_layer_sequencer: RTL and testbench

MLP_LAYER_SEQUENCER -- requirements
Module: mlp_layer_sequencer

---
 rtl/mlp_layer_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_mlp_layer_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_layer_sequencer.sv
// Chains NUM_LAYERS fully-connected layers: fills each layer's input buffer,
// starts it, waits for completion and forwards activations downstream.
package mlp_seq_pkg;
  function automatic int max_entry(
    input logic [143:0] sz,
    input int           n
  );
    int m;
    m = 1;
    for (int i = 0; i <= n; i++)
      if (int'(sz[i*16 +: 16]) > m)
        m = int'(sz[i*16 +: 16]);
    return m;
  endfunction

  function automatic int addr_bits(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction
endpackage

module mlp_layer_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int NUM_LAYERS    = 4,
  parameter int datatype_size = 2,
  parameter logic [(NUM_LAYERS+1)*16-1:0] LAYER_SIZE =
    {16'd10, 16'd250, 16'd500, 16'd784, 16'd784},
  localparam int ADDR_W =
    addr_bits(max_entry(144'(LAYER_SIZE), NUM_LAYERS))
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_in_valid,
  input  logic [datatype_size-1:0]        i_in_data,
  output logic                            o_in_ready,
  output logic [NUM_LAYERS-1:0]           o_ibuf_we,
  output logic [NUM_LAYERS*datatype_size-1:0] o_ibuf_wr_data,
  output logic [NUM_LAYERS*ADDR_W-1:0]    o_ibuf_addr,
  output logic [NUM_LAYERS-1:0]           o_start,
  input  logic [NUM_LAYERS-1:0]           i_busy,
  input  logic [NUM_LAYERS-1:0]           i_func_valid,
  input  logic [NUM_LAYERS*datatype_size-1:0] i_func_data,
  output logic                            o_out_valid,
  output logic [datatype_size-1:0]        o_out_data,
  output logic                            o_done,
  output logic                            o_err
);

  localparam int DW = datatype_size;
  localparam int CW = ADDR_W + 1;
  localparam int NL = NUM_LAYERS;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e            st_q   [NL];
  state_e            st_d   [NL];
  logic [CW-1:0]     cnt_q  [NL];
  logic [CW-1:0]     cnt_d  [NL];
  logic              seen_q [NL];
  logic              seen_d [NL];
  logic [ADDR_W-1:0] addr_q [NL];
  logic [ADDR_W-1:0] addr_d [NL];
  logic [DW-1:0]     wdat_q [NL];
  logic [DW-1:0]     wdat_d [NL];
  logic [DW-1:0]     src_dat [NL];
  logic [NL-1:0]     we_q, we_d;
  logic [NL-1:0]     src_v, down_free;
  logic              in_rdy;
  logic              ov_q, ov_d;
  logic [DW-1:0]     od_q, od_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [16:0]       ocnt_q, ocnt_d, oc;

  function automatic logic [16:0] sz(input int k);
    return {1'b0, LAYER_SIZE[k*16 +: 16]};
  endfunction

  assign in_rdy = (st_q[0] == FILL) &&
                  (17'(cnt_q[0]) < sz(0));

  always_comb begin
    src_v     = '0;
    down_free = '1;
    for (int k = 0; k < NL; k++)
      src_dat[k] = '0;
    src_v[0]   = i_in_valid & in_rdy;
    src_dat[0] = i_in_data;
    for (int k = 1; k < NL; k++) begin
      src_v[k]   = i_func_valid[k-1];
      src_dat[k] = i_func_data[(k-1)*DW +: DW];
    end
    // A layer may only start once its consumer is empty and idle.
    for (int k = 0; k < NL-1; k++)
      down_free[k] = (st_q[k+1] == FILL) &&
                     (cnt_q[k+1] == '0);
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    seen_d = seen_q;
    addr_d = addr_q;
    wdat_d = wdat_q;
    we_d   = '0;
    err_d  = err_q;
    ov_d   = 1'b0;
    od_d   = od_q;
    done_d = 1'b0;
    for (int k = 0; k < NL; k++) begin
      if (src_v[k]) begin
        if (st_q[k] == FILL &&
            17'(cnt_q[k]) < sz(k)) begin
          we_d[k]   = 1'b1;
          addr_d[k] = cnt_q[k][ADDR_W-1:0];
          wdat_d[k] = src_dat[k];
          cnt_d[k]  = cnt_q[k] + CW'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      unique case (st_q[k])
        FILL: begin
          // An arriving write holds off the start.
          if (17'(cnt_q[k]) == sz(k) && !i_busy[k] &&
              down_free[k] && !src_v[k]) begin
            st_d[k]   = START;
            seen_d[k] = 1'b0;
          end
        end
        START: begin
          st_d[k]   = WAIT;
          seen_d[k] = i_busy[k];
        end
        WAIT: begin
          if (i_busy[k]) begin
            seen_d[k] = 1'b1;
          end else if (seen_q[k]) begin
            st_d[k]   = FILL;
            cnt_d[k]  = '0;
            seen_d[k] = 1'b0;
          end
        end
        default: st_d[k] = FILL;
      endcase
    end
    // Output count holds at full until the last layer restarts,
    // so surplus words remain detectable.
    oc     = (st_q[NL-1] == START) ? '0 : ocnt_q;
    ocnt_d = oc;
    if (i_func_valid[NL-1]) begin
      if (oc < sz(NL)) begin
        ov_d   = 1'b1;
        od_d   = i_func_data[(NL-1)*DW +: DW];
        ocnt_d = oc + 17'd1;
        done_d = (oc + 17'd1) == sz(NL);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NL; k++) begin
        st_q[k]   <= FILL;
        cnt_q[k]  <= '0;
        seen_q[k] <= 1'b0;
        addr_q[k] <= '0;
        wdat_q[k] <= '0;
      end
      we_q   <= '0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      ocnt_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
      addr_q <= addr_d;
      wdat_q <= wdat_d;
      we_q   <= we_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
      done_q <= done_d;
      err_q  <= err_d;
      ocnt_q <= ocnt_d;
    end
  end

  always_comb begin
    o_start        = '0;
    o_ibuf_addr    = '0;
    o_ibuf_wr_data = '0;
    for (int k = 0; k < NL; k++) begin
      o_start[k] = (st_q[k] == START);
      o_ibuf_addr[k*ADDR_W +: ADDR_W] = addr_q[k];
      o_ibuf_wr_data[k*DW +: DW]      = wdat_q[k];
    end
  end

  assign o_in_ready  = in_rdy;
  assign o_ibuf_we   = we_q;
  assign o_out_valid = ov_q;
  assign o_out_data  = od_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for mlp_layer_sequencer: two layers, sizes 4 -> 3 -> 2.
// Expected values are hand-derived from the sequencing rules.
module tb_mlp_layer_sequencer;

  localparam int NL = 2;
  localparam int DW = 2;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [NL-1:0] ibuf_we;
  logic [NL*DW-1:0] ibuf_wd;
  logic [NL*AW-1:0] ibuf_addr;
  logic [NL-1:0] start;
  logic [NL-1:0] busy = '0;
  logic [NL-1:0] fvalid = '0;
  logic [NL*DW-1:0] fdata = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          done;
  logic          err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mlp_layer_sequencer #(
    .NUM_LAYERS    (NL),
    .datatype_size (DW),
    .LAYER_SIZE    ({16'd2, 16'd3, 16'd4})
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_in_valid     (in_valid),
    .i_in_data      (in_data),
    .o_in_ready     (in_ready),
    .o_ibuf_we      (ibuf_we),
    .o_ibuf_wr_data (ibuf_wd),
    .o_ibuf_addr    (ibuf_addr),
    .o_start        (start),
    .i_busy         (busy),
    .i_func_valid   (fvalid),
    .i_func_data    (fdata),
    .o_out_valid    (out_valid),
    .o_out_data     (out_data),
    .o_done         (done),
    .o_err          (err)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_inputs(input int base);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(base + i);
      tick();
      chk("in_we", 32'(ibuf_we[0]), 1);
      chk("in_addr", 32'(ibuf_addr[0 +: AW]), i);
      chk("in_wd", 32'(ibuf_wd[0 +: DW]), (base + i) % 4);
    end
    in_valid = 1'b0;
    chk("rdy_full", 32'(in_ready), 0);
  endtask

  task automatic l1_emit(input int base);
    for (int i = 0; i < 3; i++) begin
      fvalid[0]        = 1'b1;
      fdata[0 +: DW]   = DW'(base + i);
      tick();
      chk("f_we", 32'(ibuf_we[1]), 1);
      chk("f_addr", 32'(ibuf_addr[AW +: AW]), i);
      chk("f_wd", 32'(ibuf_wd[DW +: DW]), (base + i) % 4);
    end
  endtask

  task automatic l2_emit2(input int d0, input int d1);
    fvalid[1]       = 1'b1;
    fdata[DW +: DW] = DW'(d0);
    tick();
    chk("ov0", 32'(out_valid), 1);
    chk("od0", 32'(out_data), d0);
    chk("done0", 32'(done), 0);
    fdata[DW +: DW] = DW'(d1);
    tick();
    chk("ov1", 32'(out_valid), 1);
    chk("od1", 32'(out_data), d1);
    chk("done1", 32'(done), 1);
    fvalid[1] = 1'b0;
    tick();
    chk("ov_idle", 32'(out_valid), 0);
    chk("done_idle", 32'(done), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    #2 rst = 1'b1;
    tick();
    chk("rst_we", 32'(ibuf_we), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdy", 32'(in_ready), 1);
    tick();
    rst = 1'b0;

    // Inference 1: fill layer 1, start it.
    push_inputs(1);
    chk("no_start_yet", 32'(start), 0);
    tick();
    chk("start1", 32'(start), 2'b01);
    chk("we_off", 32'(ibuf_we), 0);
    busy[0] = 1'b1;
    tick();
    chk("start1_end", 32'(start), 0);
    repeat (4) tick();
    l1_emit(1);
    fvalid[0] = 1'b0;
    busy[0]   = 1'b0;
    tick();
    chk("start2", 32'(start), 2'b10);
    chk("rdy_refill", 32'(in_ready), 1);
    busy[1] = 1'b1;
    tick();
    l2_emit2(2, 1);
    chk("err_clean", 32'(err), 0);

    // Inference 2 fills layer 1 while layer 2 is still busy.
    push_inputs(0);
    repeat (3) begin
      tick();
      chk("start_held", 32'(start), 0);
    end
    busy[1] = 1'b0;
    tick();
    chk("start_held2", 32'(start), 0);
    tick();
    chk("start1_b", 32'(start), 2'b01);

    // Layer 1 overproduces: fourth word is dropped.
    busy[0] = 1'b1;
    tick();
    l1_emit(3);
    fdata[0 +: DW] = 2'd2;
    tick();
    chk("drop_we", 32'(ibuf_we[1]), 0);
    chk("err_set", 32'(err), 1);
    chk("drop_start", 32'(start), 0);
    fvalid[0] = 1'b0;
    tick();
    chk("start2_b", 32'(start), 2'b10);
    chk("err_sticky", 32'(err), 1);
    busy[1] = 1'b1;
    tick();
    tick();
    chk("err_sticky2", 32'(err), 1);

    // Reset during layer-2 WAIT.
    rst = 1'b1;
    #1;
    chk("mr_we", 32'(ibuf_we), 0);
    chk("mr_start", 32'(start), 0);
    chk("mr_ov", 32'(out_valid), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_err", 32'(err), 0);
    chk("mr_addr", 32'(ibuf_addr), 0);
    chk("mr_wd", 32'(ibuf_wd), 0);
    chk("mr_od", 32'(out_data), 0);
    busy = '0;
    tick();
    rst = 1'b0;
    chk("mr_rdy", 32'(in_ready), 1);

    // Fresh inference after reset.
    push_inputs(2);
    tick();
    chk("start1_c", 32'(start), 2'b01);
    busy[0] = 1'b1;
    tick();
    l1_emit(0);
    fvalid[0] = 1'b0;
    busy[0]   = 1'b0;
    tick();
    chk("start2_c", 32'(start), 2'b10);
    busy[1] = 1'b1;
    tick();
    l2_emit2(3, 0);
    chk("err_clean2", 32'(err), 0);

    // Surplus last-layer word.
    fvalid[1]       = 1'b1;
    fdata[DW +: DW] = 2'd1;
    tick();
    fvalid[1] = 1'b0;
    chk("extra_ov", 32'(out_valid), 0);
    chk("extra_err", 32'(err), 1);
    tick();
    chk("extra_done", 32'(done), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
